// File: rtl/player_motion_ctrl_pkg.sv
// player_motion_ctrl_pkg: state encoding, key indices and screen/motion constants shared with platformer_display.
package player_motion_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GROUND = 2'd1, ST_AIR = 2'd2} state_e;
  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT = 1;
  localparam int KEY_JUMP = 2;
  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] PLAYER_W = 10'd16;
  localparam logic [9:0] GROUND_Y = 10'd400;
  localparam logic [9:0] START_X = 10'd32;
  localparam logic [9:0] X_MAX = SCREEN_W - PLAYER_W;
  localparam logic signed [5:0] JUMP_V = 6'sd12;
  localparam logic signed [5:0] GRAVITY = 6'sd1;
  localparam logic signed [5:0] MAX_FALL = 6'sd12;
  localparam logic [9:0] JUMP_Y = GROUND_Y - {4'd0, JUMP_V};
  localparam logic signed [5:0] VY_LAUNCH = GRAVITY - JUMP_V;
endpackage

// File: rtl/player_motion_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser for active-low keys, giving active-high levels and rising-edge pulses.
module btn_sync_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_n_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q, prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
      prev_q <= '0;
    end else begin
      s1_q <= btn_n_i;
      s2_q <= s1_q;
      prev_q <= level_o;
    end
  assign level_o = ~s2_q;
  assign rise_o = level_o & ~prev_q;
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame ground/air motion sequencer producing the player sprite position.
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic [2:0] speed_select_i,
  input  logic [2:0] control_i,
  output logic [9:0] player_x_o,
  output logic [9:0] player_y_o,
  output logic [1:0] state_o,
  output logic       airborne_o,
  output logic       update_done_o
);
  logic [2:0] key, rise;
  logic unused_keys;
  state_e state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, x_hv;
  logic signed [5:0] vy_q, vy_d, vy_sat;
  logic signed [6:0] vy_inc;
  logic signed [10:0] x_r, x_l, y_sum;
  logic [3:0] step;
  logic pend_q, pend_d, done_q, go, idle, landed, right, left;
  btn_sync_edge #(.W(3)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n_i(control_i),
    .level_o(key),
    .rise_o (rise)
  );
  assign unused_keys = ^{key[KEY_JUMP], rise[KEY_LEFT], rise[KEY_RIGHT]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = !frame_tick_i ? state_q :
              !start_i ? ST_IDLE :
              state_q == ST_IDLE ? ST_GROUND :
              state_q == ST_GROUND ? (pend_q ? ST_AIR : ST_GROUND) :
              landed ? ST_GROUND : ST_AIR;
  always_comb begin
    state_o = state_q;
    airborne_o = state_q == ST_AIR;
  end
  // Sums are widened to 11-bit signed so clamping sees overflow and underflow before truncation
  assign step = {1'b0, speed_select_i} + 4'd1;
  assign x_r = $signed({1'b0, x_q}) + $signed({7'd0, step});
  assign x_l = $signed({1'b0, x_q}) - $signed({7'd0, step});
  assign y_sum = $signed({1'b0, y_q}) + $signed({{5{vy_q[5]}}, vy_q});
  assign vy_inc = $signed({vy_q[5], vy_q}) + $signed({GRAVITY[5], GRAVITY});
  assign vy_sat = vy_inc > $signed({MAX_FALL[5], MAX_FALL}) ? MAX_FALL : vy_inc[5:0];
  assign landed = y_sum >= $signed({1'b0, GROUND_Y});
  assign right = key[KEY_RIGHT] & ~key[KEY_LEFT];
  assign left = key[KEY_LEFT] & ~key[KEY_RIGHT];
  assign x_hv = right ? (x_r > $signed({1'b0, X_MAX}) ? X_MAX : x_r[9:0]) :
                left ? (x_l[10] ? 10'd0 : x_l[9:0]) : x_q;
  assign go = frame_tick_i & start_i & (state_q != ST_IDLE);
  assign idle = (state_q == ST_IDLE) | (frame_tick_i & ~start_i);
  always_comb begin
    x_d = idle ? START_X : go ? x_hv : x_q;
    y_d = idle ? GROUND_Y : !go ? y_q :
          state_q == ST_GROUND ? (pend_q ? JUMP_Y : GROUND_Y) :
          landed ? GROUND_Y : y_sum[9:0];
    vy_d = idle ? 6'sd0 : !go ? vy_q :
           state_q == ST_GROUND ? (pend_q ? VY_LAUNCH : 6'sd0) :
           landed ? 6'sd0 : vy_sat;
    pend_d = (state_q == ST_GROUND) & ((pend_q & ~(frame_tick_i & start_i)) | rise[KEY_JUMP]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_q <= START_X;
      y_q <= GROUND_Y;
      vy_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      vy_q <= vy_d;
      pend_q <= pend_d;
      done_q <= frame_tick_i;
    end
  assign player_x_o = x_q;
  assign player_y_o = y_q;
  assign update_done_o = done_q;
endmodule
